// File: rtl/mypkg.sv
// Shared definitions for the L1 lookup-port arbiter: trace command codes,
// requester/state encodings and a command legality helper.
package mypkg;

    // Trace command codes
    localparam int unsigned READ       = 0;
    localparam int unsigned WRITE      = 1;
    localparam int unsigned I_FETCH    = 2;
    localparam int unsigned L2_INVAL   = 3;
    localparam int unsigned L2_DATA_RQ = 4;
    localparam int unsigned CLR        = 8;
    localparam int unsigned PRINT      = 9;

    // Width of the optional statistics counters
    localparam int ARB_STAT_W = 32;

    typedef enum logic [1:0] {
        SRC_D = 2'd0,
        SRC_I = 2'd1,
        SRC_S = 2'd2
    } arb_src_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DROP  = 2'd3
    } arb_state_e;

    // True when the command may legally be issued by the given requester.
    // Fetches carry an implicit I_FETCH and are always legal.
    function automatic logic cmd_legal(input logic [1:0] src, input int unsigned cmd);
        logic ok;
        ok = 1'b0;
        case (src)
            SRC_D:   ok = (cmd == READ) || (cmd == WRITE) || (cmd == CLR) || (cmd == PRINT);
            SRC_I:   ok = 1'b1;
            SRC_S:   ok = (cmd == L2_INVAL) || (cmd == L2_DATA_RQ);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cache_arb_pick.sv
// Combinational chooser for the lookup port: snoop first unless the snoop
// run has starved a waiting CPU requester, then round-robin between D and I.
module cache_arb_pick
    import mypkg::*;
(
    input  logic       d_valid,
    input  logic       i_valid,
    input  logic       s_valid,
    input  logic       ptr_i,
    input  logic       run_max,
    output logic       any_valid,
    output logic [1:0] src
);

    // Select one source; src is only meaningful while any_valid is high
    always_comb begin
        any_valid = d_valid | i_valid | s_valid;
        src       = SRC_D;
        if (s_valid && !(run_max && (d_valid || i_valid))) begin
            src = SRC_S;
        end else if (d_valid && i_valid) begin
            src = ptr_i ? SRC_I : SRC_D;
        end else if (i_valid) begin
            src = SRC_I;
        end else begin
            src = SRC_D;
        end
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Arbiter for the single L1 cache lookup port, shared by the data port,
// the instruction fetch port and the L2 snoop port. One lookup is in flight
// at a time; the response is routed back to whichever port issued it.
// Optional macro CACHE_ARB_STATS_EN adds saturating grant/drop counters;
// without it the stat_* ports read as zero.
module cache_req_arbiter
    import mypkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int CMD_W         = 4,
    parameter int MAX_SNOOP_RUN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [CMD_W-1:0]      d_req_cmd,
    input  logic [ADDR_W-1:0]     d_req_addr,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic                  s_req_valid,
    output logic                  s_req_ready,
    input  logic [CMD_W-1:0]      s_req_cmd,
    input  logic [ADDR_W-1:0]     s_req_addr,
    output logic                  c_req_valid,
    input  logic                  c_req_ready,
    output logic [CMD_W-1:0]      c_req_cmd,
    output logic [ADDR_W-1:0]     c_req_addr,
    output logic [1:0]            c_req_src,
    input  logic                  c_rsp_valid,
    input  logic                  c_rsp_hit,
    output logic                  d_rsp_valid,
    output logic                  i_rsp_valid,
    output logic                  s_rsp_valid,
    output logic                  rsp_hit,
    output logic                  busy,
    output logic [ARB_STAT_W-1:0] stat_d_grants,
    output logic [ARB_STAT_W-1:0] stat_i_grants,
    output logic [ARB_STAT_W-1:0] stat_s_grants,
    output logic [ARB_STAT_W-1:0] stat_drops,
    output logic [ARB_STAT_W-1:0] stat_starve_overrides
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_DROP  = DROP;
    localparam int         RUN_W    = $clog2(MAX_SNOOP_RUN + 1);

    logic [1:0]        state;
    logic              ptr_i;
    logic [RUN_W-1:0]  run_cnt;
    logic              run_max;
    logic              pick_any;
    logic [1:0]        pick_src;
    logic              accept;
    logic [CMD_W-1:0]  sel_cmd;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_legal;
    logic              cpu_waiting;
    logic [CMD_W-1:0]  cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        src_q;
    logic              rsp_fire;

    assign run_max     = (run_cnt == RUN_W'(MAX_SNOOP_RUN));
    assign cpu_waiting = d_req_valid | i_req_valid;

    cache_arb_pick u_pick (
        .d_valid   (d_req_valid),
        .i_valid   (i_req_valid),
        .s_valid   (s_req_valid),
        .ptr_i     (ptr_i),
        .run_max   (run_max),
        .any_valid (pick_any),
        .src       (pick_src)
    );

    assign accept = (state == ST_IDLE) && pick_any;

    // Mux the chosen requester's command/address and judge its legality
    always_comb begin
        sel_cmd  = d_req_cmd;
        sel_addr = d_req_addr;
        case (pick_src)
            SRC_I: begin
                sel_cmd  = CMD_W'(I_FETCH);
                sel_addr = i_req_addr;
            end
            SRC_S: begin
                sel_cmd  = s_req_cmd;
                sel_addr = s_req_addr;
            end
            default: begin
                sel_cmd  = d_req_cmd;
                sel_addr = d_req_addr;
            end
        endcase
        sel_legal = cmd_legal(pick_src, int'(sel_cmd));
    end

    assign d_req_ready = accept && (pick_src == SRC_D);
    assign i_req_ready = accept && (pick_src == SRC_I);
    assign s_req_ready = accept && (pick_src == SRC_S);

    // Control: FSM, D/I round-robin pointer and snoop run counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr_i   <= 1'b0;
            run_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= sel_legal ? ST_ISSUE : ST_DROP;
                        if (pick_src == SRC_S) begin
                            if (cpu_waiting && !run_max) begin
                                run_cnt <= run_cnt + RUN_W'(1);
                            end
                        end else begin
                            run_cnt <= '0;
                            ptr_i   <= (pick_src == SRC_D);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (c_req_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (c_rsp_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture the accepted request; only observed outside IDLE
    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_q  <= sel_cmd;
            addr_q <= sel_addr;
            src_q  <= pick_src;
        end
    end

    // Cache-side request and per-requester response routing
    always_comb begin
        c_req_valid = (state == ST_ISSUE);
        c_req_cmd   = c_req_valid ? cmd_q  : '0;
        c_req_addr  = c_req_valid ? addr_q : '0;
        c_req_src   = c_req_valid ? src_q  : 2'd0;
        rsp_fire    = ((state == ST_WAIT) && c_rsp_valid) || (state == ST_DROP);
        d_rsp_valid = rsp_fire && (src_q == SRC_D);
        i_rsp_valid = rsp_fire && (src_q == SRC_I);
        s_rsp_valid = rsp_fire && (src_q == SRC_S);
        rsp_hit     = (state == ST_WAIT) && c_rsp_valid && c_rsp_hit;
        busy        = (state != ST_IDLE);
    end

`ifdef CACHE_ARB_STATS_EN
    logic grant_d;
    logic grant_i;
    logic grant_s;
    logic grant_drop;
    logic grant_forced;
    logic grant_clr;

    function automatic logic [ARB_STAT_W-1:0] sat_inc(input logic [ARB_STAT_W-1:0] v,
                                                      input logic en);
        return (en && (v != '1)) ? v + ARB_STAT_W'(1) : v;
    endfunction

    assign grant_d      = accept && (pick_src == SRC_D);
    assign grant_i      = accept && (pick_src == SRC_I);
    assign grant_s      = accept && (pick_src == SRC_S);
    assign grant_drop   = accept && !sel_legal;
    assign grant_forced = accept && (pick_src != SRC_S) && s_req_valid;
    assign grant_clr    = grant_d && (d_req_cmd == CMD_W'(CLR));

    // Saturating event counters; a granted D-port CLR wipes them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_d_grants         <= '0;
            stat_i_grants         <= '0;
            stat_s_grants         <= '0;
            stat_drops            <= '0;
            stat_starve_overrides <= '0;
        end else if (grant_clr) begin
            stat_d_grants         <= '0;
            stat_i_grants         <= '0;
            stat_s_grants         <= '0;
            stat_drops            <= '0;
            stat_starve_overrides <= '0;
        end else begin
            stat_d_grants         <= sat_inc(stat_d_grants, grant_d);
            stat_i_grants         <= sat_inc(stat_i_grants, grant_i);
            stat_s_grants         <= sat_inc(stat_s_grants, grant_s);
            stat_drops            <= sat_inc(stat_drops, grant_drop);
            stat_starve_overrides <= sat_inc(stat_starve_overrides, grant_forced);
        end
    end
`else
    assign stat_d_grants         = '0;
    assign stat_i_grants         = '0;
    assign stat_s_grants         = '0;
    assign stat_drops            = '0;
    assign stat_starve_overrides = '0;
`endif

endmodule
